// File: rtl/midi_pkg.sv
// midi_pkg: shared parse-state enum, MIDI opcode constants and default slot geometry.
package midi_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_NOTE, WAIT_VEL} parse_state_e;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam int DEF_NUM_SLOTS = 10;
  localparam int DEF_SLOT_W = 8;
endpackage

// File: rtl/midi_note_tracker_if.sv
// midi_note_tracker_if: MIDI byte stream in, held-note slot vector and status pulses out.
interface midi_note_tracker_if import midi_pkg::*; #(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_W = DEF_SLOT_W
);
  logic [7:0] midi_byte_in;
  logic midi_valid_in;
  logic [3:0] channel_in;
  logic [NUM_SLOTS*SLOT_W-1:0] received_note;
  logic [3:0] note_count;
  logic notes_changed;
  logic overflow;
  modport master (
    output midi_byte_in, midi_valid_in, channel_in,
    input received_note, note_count, notes_changed, overflow
  );
  modport slave (
    input midi_byte_in, midi_valid_in, channel_in,
    output received_note, note_count, notes_changed, overflow
  );
endinterface

// File: rtl/midi_slot_finder.sv
// midi_slot_finder: combinational search for the lowest free slot and the slot holding a note.
module midi_slot_finder #(
  parameter int NUM_SLOTS = 10,
  parameter int SLOT_W = 8,
  localparam int IDX_W = $clog2(NUM_SLOTS)
) (
  input logic [NUM_SLOTS*SLOT_W-1:0] slots,
  input logic [6:0] note,
  output logic [IDX_W-1:0] lowest_free_idx,
  output logic free_found,
  output logic [IDX_W-1:0] match_idx,
  output logic match_found
);
  // Scanning downwards lets the last hit win, which is the lowest index.
  always_comb begin
    lowest_free_idx = '0;
    free_found = 1'b0;
    match_idx = '0;
    match_found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i*SLOT_W+SLOT_W-1]) begin
        lowest_free_idx = IDX_W'(i);
        free_found = 1'b1;
      end
      if (slots[i*SLOT_W+SLOT_W-1] && slots[i*SLOT_W +: 7] == note) begin
        match_idx = IDX_W'(i);
        match_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/midi_note_tracker.sv
// midi_note_tracker: parses MIDI note-on/off for one channel into a table of held notes.
// Define MIDI_RUNNING_STATUS_EN to let data-byte pairs reuse the last opcode.
module midi_note_tracker import midi_pkg::*; #(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input logic clk_camera_in,
  input logic rst_in,
  midi_note_tracker_if.slave m
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
`ifdef MIDI_RUNNING_STATUS_EN
  localparam parse_state_e DONE_STATE = WAIT_NOTE;
`else
  localparam parse_state_e DONE_STATE = IDLE;
`endif
  parse_state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [6:0] note_q, note_d;
  logic [NUM_SLOTS*SLOT_W-1:0] slots_q, slots_d;
  logic changed_q, changed_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] free_idx, match_idx;
  logic free_found, match_found;
  logic is_rt, accept, is_data, complete, is_on, write_on, write_off;
  logic [3:0] cnt;
  midi_slot_finder #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_finder (
    .slots(slots_q),
    .note(note_q),
    .lowest_free_idx(free_idx),
    .free_found(free_found),
    .match_idx(match_idx),
    .match_found(match_found)
  );
  assign is_rt = m.midi_byte_in >= REALTIME_MIN;
  assign accept = (m.midi_byte_in[7:4] == NOTE_OFF || m.midi_byte_in[7:4] == NOTE_ON)
                  && m.midi_byte_in[3:0] == m.channel_in;
  assign is_data = m.midi_valid_in && !m.midi_byte_in[7];
  assign complete = is_data && state_q == WAIT_VEL;
  assign is_on = op_q == NOTE_ON && m.midi_byte_in[6:0] != 7'd0;
  assign write_on = complete && is_on && !match_found && free_found;
  assign write_off = complete && !is_on && match_found;
  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      op_q <= '0;
      note_q <= '0;
      slots_q <= '0;
      changed_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      note_q <= note_d;
      slots_q <= slots_d;
      changed_q <= changed_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    note_d = note_q;
    if (m.midi_valid_in && m.midi_byte_in[7] && !is_rt) begin
      state_d = accept ? WAIT_NOTE : IDLE;
      op_d = accept ? m.midi_byte_in[7:4] : op_q;
    end else if (is_data && state_q == WAIT_NOTE) begin
      state_d = WAIT_VEL;
      note_d = m.midi_byte_in[6:0];
    end else if (complete) begin
      state_d = DONE_STATE;
    end
  end
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (write_on && free_idx == IDX_W'(i)) slots_d[i*SLOT_W +: SLOT_W] = SLOT_W'({1'b1, note_q});
      if (write_off && match_idx == IDX_W'(i)) slots_d[i*SLOT_W +: SLOT_W] = '0;
    end
    changed_d = slots_d != slots_q;
    ovf_d = complete && is_on && !match_found && !free_found;
  end
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) cnt = cnt + 4'(slots_q[i*SLOT_W+SLOT_W-1]);
  end
  assign m.received_note = slots_q;
  assign m.note_count = cnt;
  assign m.notes_changed = changed_q;
  assign m.overflow = ovf_q;
endmodule

// File: tb/tb_midi_note_tracker.sv
// tb_midi_note_tracker: directed byte sequences against hand-computed slot tables.
module tb_midi_note_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [79:0] exp_rn;
  midi_note_tracker_if #(.NUM_SLOTS(10), .SLOT_W(8)) bus ();
  midi_note_tracker #(.NUM_SLOTS(10), .SLOT_W(8)) dut (
    .clk_camera_in(clk),
    .rst_in(rst),
    .m(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.midi_byte_in = b;
    bus.midi_valid_in = 1'b1;
    @(negedge clk);
    bus.midi_valid_in = 1'b0;
  endtask

  task automatic msg(input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
    send(s);
    send(n);
    send(v);
  endtask

  task automatic outs(input string tag, input logic [79:0] rn, input logic [3:0] cnt,
                      input logic chg, input logic ovf);
    chk({tag, "_rn"}, bus.received_note, rn);
    chk({tag, "_cnt"}, 80'(bus.note_count), 80'(cnt));
    chk({tag, "_chg"}, 80'(bus.notes_changed), 80'(chg));
    chk({tag, "_ovf"}, 80'(bus.overflow), 80'(ovf));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 outs("async_rst", '0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.midi_byte_in = 8'h00;
    bus.midi_valid_in = 1'b0;
    bus.channel_in = 4'd0;
    repeat (2) @(negedge clk);
    outs("reset", '0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    msg(8'h90, 8'h3C, 8'h40);
    outs("on_3c", 80'hBC, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("chg_one_cycle", 80'(bus.notes_changed), 80'd0);
    msg(8'h80, 8'h3C, 8'h00);
    outs("off_3c", '0, 4'd0, 1'b1, 1'b0);
    msg(8'h80, 8'h3C, 8'h00);
    outs("off_absent", '0, 4'd0, 1'b0, 1'b0);
    msg(8'h90, 8'h3C, 8'h40);
    msg(8'h90, 8'h3C, 8'h50);
    outs("dup_on", 80'hBC, 4'd1, 1'b0, 1'b0);
    msg(8'h90, 8'h3C, 8'h00);
    outs("vel0_off", '0, 4'd0, 1'b1, 1'b0);
    exp_rn = '0;
    for (int i = 0; i < 10; i++) begin
      msg(8'h90, 8'h3C + 8'(i), 8'h40);
      exp_rn[i*8 +: 8] = 8'hBC + 8'(i);
    end
    outs("full", exp_rn, 4'd10, 1'b1, 1'b0);
    msg(8'h90, 8'h50, 8'h40);
    outs("overflow", exp_rn, 4'd10, 1'b0, 1'b1);
    msg(8'h80, 8'h40, 8'h00);
    exp_rn[39:32] = 8'h00;
    outs("hole4", exp_rn, 4'd9, 1'b1, 1'b0);
    msg(8'h80, 8'h38, 8'h00);
    outs("off_absent_full", exp_rn, 4'd9, 1'b0, 1'b0);
    msg(8'h90, 8'h50, 8'h40);
    exp_rn[39:32] = 8'hD0;
    outs("refill4", exp_rn, 4'd10, 1'b1, 1'b0);
    pulse_reset();
    send(8'h90);
    send(8'hF8);
    send(8'h3C);
    send(8'hFE);
    send(8'h40);
    outs("realtime", 80'hBC, 4'd1, 1'b1, 1'b0);
    msg(8'h80, 8'h3C, 8'h00);
    msg(8'h91, 8'h3C, 8'h40);
    outs("other_chan", '0, 4'd0, 1'b0, 1'b0);
    bus.channel_in = 4'd1;
    msg(8'h91, 8'h3E, 8'h40);
    outs("chan1", 80'hBE, 4'd1, 1'b1, 1'b0);
    msg(8'h81, 8'h3E, 8'h00);
    bus.channel_in = 4'd0;
    send(8'h90);
    send(8'h3C);
    send(8'hF0);
    send(8'h40);
    outs("sysex_abort", '0, 4'd0, 1'b0, 1'b0);
    msg(8'hB0, 8'h3C, 8'h40);
    outs("other_op", '0, 4'd0, 1'b0, 1'b0);
    msg(8'hF0, 8'h3C, 8'h40);
    outs("idle_data", '0, 4'd0, 1'b0, 1'b0);
    msg(8'h90, 8'h3C, 8'h40);
    send(8'h3E);
    send(8'h40);
`ifdef MIDI_RUNNING_STATUS_EN
    outs("running", 80'hBEBC, 4'd2, 1'b1, 1'b0);
`else
    outs("running", 80'hBC, 4'd1, 1'b0, 1'b0);
`endif
    pulse_reset();
    send(8'h90);
    send(8'h3C);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 outs("mid_rst", '0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h40);
    outs("post_rst", '0, 4'd0, 1'b0, 1'b0);
    send(8'h3C);
    send(8'h40);
    outs("post_rst_idle", '0, 4'd0, 1'b0, 1'b0);
    msg(8'h90, 8'h41, 8'h40);
    outs("post_rst_fresh", 80'hC1, 4'd1, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
